// File: rtl/tdr_pulse_if.sv
// tdr_pulse_if: control/status bundle of the TDR pulse generator
// master drives trigger, abort and cfg_*; slave (the generator) drives pulse, sync, busy, done, err_cfg
interface tdr_pulse_if #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    logic               trigger;
    logic               abort;
    logic [CNT_W-1:0]   cfg_width;
    logic [CNT_W-1:0]   cfg_period;
    logic [BURST_W-1:0] cfg_count;
    logic               pulse;
    logic               sync;
    logic               busy;
    logic               done;
    logic               err_cfg;
    modport master(output trigger, abort, cfg_width, cfg_period, cfg_count,
                   input pulse, sync, busy, done, err_cfg);
    modport slave(input trigger, abort, cfg_width, cfg_period, cfg_count,
                  output pulse, sync, busy, done, err_cfg);
endinterface

// File: rtl/tdr_pulse_gen.sv
// tdr_pulse_gen: programmable burst pulse generator for TDR stimulus
// clk, rst (async, active-high); bus.slave: trigger/abort/cfg_* in, pulse/sync/busy/done/err_cfg out
module tdr_pulse_gen #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input logic        clk,
    input logic        rst,
    tdr_pulse_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
    state_t             st, nxt;
    logic               trigger_d, trig_edge, cfg_ok, ld, sync_n, done_n, err_n;
    logic [CNT_W-1:0]   cyc, cyc_n, w, p;
    logic [BURST_W-1:0] pcnt, pcnt_n, c;
    assign trig_edge = bus.trigger & ~trigger_d;
    assign cfg_ok    = (bus.cfg_width != '0) && (bus.cfg_period > bus.cfg_width);
    always_comb begin
        nxt    = st;
        cyc_n  = cyc;
        pcnt_n = pcnt;
        ld     = 1'b0;
        sync_n = 1'b0;
        done_n = 1'b0;
        err_n  = 1'b0;
        case (st)
            IDLE: if (trig_edge && !bus.abort) begin
                if (cfg_ok) begin
                    nxt    = PULSE;
                    ld     = 1'b1;
                    cyc_n  = CNT_W'(1);
                    pcnt_n = BURST_W'(1);
                    sync_n = 1'b1;
                end else
                    err_n = 1'b1;
            end
            PULSE: begin
                cyc_n = cyc + CNT_W'(1);
                nxt   = (cyc == w) ? GAP : PULSE;
            end
            GAP: if (cyc == p) begin
                if (c == '0 || pcnt < c) begin
                    nxt    = PULSE;
                    cyc_n  = CNT_W'(1);
                    // saturating so continuous bursts never wrap
                    pcnt_n = pcnt + {{(BURST_W-1){1'b0}}, ~&pcnt};
                    sync_n = 1'b1;
                end else begin
                    nxt    = IDLE;
                    done_n = 1'b1;
                end
            end else
                cyc_n = cyc + CNT_W'(1);
            default: nxt = IDLE;
        endcase
        if (bus.abort && st != IDLE) begin
            nxt    = IDLE;
            sync_n = 1'b0;
            done_n = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            trigger_d   <= 1'b0;
            cyc         <= '0;
            pcnt        <= '0;
            w           <= '0;
            p           <= '0;
            c           <= '0;
            bus.pulse   <= 1'b0;
            bus.sync    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err_cfg <= 1'b0;
        end else begin
            st          <= nxt;
            trigger_d   <= bus.trigger;
            cyc         <= cyc_n;
            pcnt        <= pcnt_n;
            w           <= ld ? bus.cfg_width : w;
            p           <= ld ? bus.cfg_period : p;
            c           <= ld ? bus.cfg_count : c;
            bus.pulse   <= nxt == PULSE;
            bus.sync    <= sync_n;
            bus.busy    <= nxt != IDLE;
            bus.done    <= done_n;
            bus.err_cfg <= err_n;
        end
    end
endmodule

// File: tb/tb_tdr_pulse_gen.sv
// tb_tdr_pulse_gen: scoreboard bench for tdr_pulse_gen against a timeline model of each burst
module tb_tdr_pulse_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] exp_q[$];
    logic prev_tr = 1'b0;
    bit   act = 1'b0;
    int   n = 0, t0 = 0, mw = 0, mp = 1, mc = 0;

    tdr_pulse_if #(.CNT_W(16), .BURST_W(8)) bus ();
    tdr_pulse_gen #(.CNT_W(16), .BURST_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Expected {pulse,sync,busy,done,err_cfg} after the next clock edge.
    // A burst accepted at edge t0 is described by m = n - t0: pulse while m%P < W,
    // sync at m%P == 0, busy while m < C*P, done at m == C*P (C == 0 never ends).
    task automatic model(input logic tr, input logic ab, input int w, input int p, input int c);
        logic [4:0] e;
        int m;
        e = '0;
        if (act && ab)
            act = 1'b0;
        else if (act) begin
            m = n - t0;
            if (mc != 0 && m == mc * mp) begin
                e[1] = 1'b1;
                act  = 1'b0;
            end else begin
                e[4] = (m % mp) < mw;
                e[3] = (m % mp) == 0;
                e[2] = 1'b1;
            end
        end else if (tr && !prev_tr && !ab) begin
            if (w != 0 && p > w) begin
                act = 1'b1;
                t0 = n; mw = w; mp = p; mc = c;
                e[4:2] = 3'b111;
            end else
                e[0] = 1'b1;
        end
        prev_tr = tr;
        n++;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic tr, input logic ab, input int w, input int p, input int c);
        @(negedge clk);
        bus.trigger    = tr;
        bus.abort      = ab;
        bus.cfg_width  = 16'(w);
        bus.cfg_period = 16'(p);
        bus.cfg_count  = 8'(c);
        model(tr, ab, w, p, c);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 3, 10, 4);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [4:0] e, a;
                e = exp_q.pop_front();
                a = {bus.pulse, bus.sync, bus.busy, bus.done, bus.err_cfg};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs at t=%0t {pulse,sync,busy,done,err_cfg} got %b want %b", $time, a, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.trigger    = 1'b1;
        bus.abort      = 1'b0;
        bus.cfg_width  = 16'd3;
        bus.cfg_period = 16'd10;
        bus.cfg_count  = 8'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.pulse, bus.sync, bus.busy, bus.done, bus.err_cfg} !== 5'b0) begin
                errors++;
                $display("FAIL reset outputs got %b want 00000",
                         {bus.pulse, bus.sync, bus.busy, bus.done, bus.err_cfg});
            end
        end
        rst = 1'b0;
        model(1'b1, 1'b0, 3, 10, 4);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 3, 10, 4);
        idle(40);
        // single edge, w=3 p=10 c=4
        drive(1'b1, 1'b0, 3, 10, 4);
        idle(45);
        // second edge at k+5 with width changed mid-burst
        drive(1'b1, 1'b0, 3, 10, 4);
        idle(4);
        drive(1'b1, 1'b0, 7, 10, 4);
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b0, 7, 10, 4);
        idle(5);
        // continuous burst aborted at k+23
        drive(1'b1, 1'b0, 2, 5, 0);
        for (int i = 0; i < 22; i++) drive(1'b0, 1'b0, 2, 5, 0);
        drive(1'b0, 1'b1, 2, 5, 0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 2, 5, 0);
        // invalid configs, then abort racing an edge in IDLE
        drive(1'b1, 1'b0, 0, 5, 1);
        idle(3);
        drive(1'b1, 1'b0, 5, 5, 1);
        idle(3);
        drive(1'b1, 1'b1, 3, 10, 4);
        idle(3);
        // edge in the done cycle, w=1 p=2 c=1
        drive(1'b1, 1'b0, 1, 2, 1);
        drive(1'b0, 1'b0, 1, 2, 1);
        drive(1'b0, 1'b0, 1, 2, 1);
        drive(1'b1, 1'b0, 1, 2, 1);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1, 2, 1);
        // randomized traffic
        begin
            logic tr;
            tr = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 7) == 0) tr = ~tr;
                drive(tr, $urandom_range(0, 49) == 0, $urandom_range(0, 5),
                      $urandom_range(0, 12), $urandom_range(0, 4));
            end
        end
        idle(2);
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdr_pulse_gen.md
# tdr_pulse_gen

Programmable TDR stimulus generator: on a trigger rising edge it emits a burst of cfg_count pulses, each cfg_width cycles high, with pulse starts spaced cfg_period cycles apart. It also emits a one-cycle sync strobe at each pulse start for the ADC capture logic. It supersedes the fixed single-cycle edge-pulse generator in the TDR front end, adding programmable width, repetition, burst length, abort and configuration checking.

## Interface
- CNT_W, 16, width of cfg_width / cfg_period and the internal cycle counter
- BURST_W, 8, width of cfg_count and the internal pulse counter

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- trigger  in  1  start request, synchronous to clk; only its rising edge is used
- abort  in  1  synchronous stop; terminates any burst
- cfg_width  in  CNT_W  pulse high time in cycles
- cfg_period  in  CNT_W  start-to-start spacing in cycles
- cfg_count  in  BURST_W  pulses per burst; 0 = continuous until abort
- pulse  out  1  TDR drive pulse
- sync  out  1  one-cycle strobe coincident with each pulse rising
- busy  out  1  burst in progress (PULSE or GAP)
- done  out  1  one-cycle strobe when a burst completes normally
- err_cfg  out  1  one-cycle strobe when a trigger is rejected for bad configuration

## Operation
- Edge detect: a registered trigger_d resets to 0. edge = trigger & ~trigger_d. A trigger held high through reset release therefore produces one edge on the first clock.
- States: IDLE, PULSE, GAP.
- IDLE, edge, abort low:
  - Config is valid iff cfg_width != 0 and cfg_period > cfg_width (unsigned).
  - If valid: latch width, period and count; go to PULSE; pulse=1, sync=1, busy=1; pulse counter=1, cycle counter=1.
  - If invalid: stay in IDLE; err_cfg=1 for one cycle; no pulse.
- PULSE: the cycle counter increments each cycle. When it reaches latched width, go to GAP and drive pulse=0.
- GAP: the cycle counter continues. When it reaches latched period:
  - If count==0, or pulse counter < count: start the next pulse (PULSE, pulse=1, sync=1, cycle counter=1, pulse counter+1). The pulse counter saturates when count==0.
  - Otherwise: go to IDLE; busy=0; done=1 for one cycle.
- Edges arriving in PULSE or GAP are ignored and not queued. trigger_d still tracks trigger.
- Config inputs are ignored except at acceptance. Changes mid-burst have no effect.
- abort in PULSE or GAP: next state is IDLE; pulse, busy and sync go to 0; done is not asserted.
- abort in IDLE with a simultaneous edge: abort wins; no start, no err_cfg.

## Timing
- Reset values: pulse=0, sync=0, busy=0, done=0, err_cfg=0, state IDLE, all counters 0, trigger_d=0.
- Latency: if an edge is sampled at clock edge k, pulse and sync are high from k+1.
- Pulse shape:
  - pulse is high for exactly cfg_width cycles.
  - Pulse n+1 rises exactly cfg_period cycles after pulse n.
  - sync is high for exactly 1 cycle per pulse.
- Burst end: busy stays high through the final GAP. The cycle busy falls is the cycle done is high, at k+1+count·period. A new edge is accepted in that same cycle (state is IDLE).
- Abort sampled at edge j: pulse=0 and busy=0 from j+1.
- Minimum legal config is width=1, period=2, giving a 50% duty square burst.

## Test plan
- Reset with trigger held high, then release -> one pulse train starts on the first clock; all outputs were 0 during reset.
- width=3, period=10, count=4, single trigger edge -> 4 pulses, each 3 cycles high, rising at k+1, k+11, k+21, k+31; sync high 4 times; done at k+41; busy high k+1..k+40.
- Same config, second trigger edge at k+5 and config changed to width=7 mid-burst -> waveform identical to the previous case; edge ignored.
- count=0, width=2, period=5, abort asserted at edge k+23 -> continuous pulses at k+1, k+6, …, k+21; pulse low and busy low from k+24; no done.
- width=0, or period=width=5 -> err_cfg for 1 cycle at k+1; pulse, busy and sync stay 0.
- Trigger edge coinciding with the done cycle (width=1, period=2, count=1) -> done at k+3 and the new burst's pulse at k+4, with no missed or extra pulse.
